bram_sp_clr: RTL and testbench

Parametrised single-port block RAM with byte-lane write enables, write-first read-during-write, an address-range check, and a hardware clear sequencer. The sequencer sweeps the array to zero after reset and on request, and drives a real `rstb_busy`. It is the next-generation data/instruction memory for the core's FPGA memory subsystem, sitting directly behind the load/store unit or the instruction fetch port.

---
 rtl/bram_pkg.sv | 23 ++
 rtl/bram_clr_seq.sv | 66 ++++++
 rtl/bram_sp_clr.sv | 162 ++++++++++++++++
 tb/tb_bram_sp_clr.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// -----------------------------------------------------------------------------
// bram_pkg
// Shared types and helpers for the single-port clearable block RAM.
//   bram_clr_state_t : clear-sequencer state (CLEAR, IDLE)
//   lane_cnt()       : number of byte lanes in a word
//   word_shift()     : byte-address to word-index shift amount
// -----------------------------------------------------------------------------
package bram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } bram_clr_state_t;

   function automatic int lane_cnt(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int word_shift(input int data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/bram_clr_seq.sv
// -----------------------------------------------------------------------------
// bram_clr_seq
// Clear sequencer: sweeps every word of the array to zero after reset and
// whenever a clear is requested from IDLE.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (returns to CLEAR, ctr = 0)
//   clr_req  in   single-cycle clear request, honoured only in IDLE
//   clr_we   out  array write strobe for the sweep
//   clr_addr out  word being cleared this cycle
//   busy     out  high exactly while the sequencer is in CLEAR
// -----------------------------------------------------------------------------
module bram_clr_seq
   import bram_pkg::*;
#(
   parameter int MEM_DEPTH = 1024,
   parameter int CTR_W     = $clog2(MEM_DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_req,
   output logic             clr_we,
   output logic [CTR_W-1:0] clr_addr,
   output logic             busy
);

   localparam logic [CTR_W-1:0] LAST_WORD = CTR_W'(MEM_DEPTH - 1);

   bram_clr_state_t  state_q;
   logic [CTR_W-1:0] ctr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         ctr_q   <= '0;
      end else begin
         case (state_q)
            CLEAR: begin
               // The edge that clears the last word also leaves the sweep.
               if (ctr_q == LAST_WORD) begin
                  state_q <= IDLE;
                  ctr_q   <= '0;
               end else begin
                  ctr_q <= ctr_q + 1'b1;
               end
            end
            IDLE: begin
               if (clr_req) begin
                  state_q <= CLEAR;
                  ctr_q   <= '0;
               end
            end
            default: begin
               state_q <= CLEAR;
               ctr_q   <= '0;
            end
         endcase
      end
   end

   // Outputs come straight from the state/counter flops.
   assign busy     = (state_q == CLEAR);
   assign clr_we   = (state_q == CLEAR);
   assign clr_addr = ctr_q;

endmodule

// File: rtl/bram_sp_clr.sv
// -----------------------------------------------------------------------------
// bram_sp_clr
// Single-port block RAM with byte-lane write enables, write-first
// read-during-write, out-of-range detection and a hardware clear sweep.
// Ports:
//   clkb      in   clock, rising edge
//   rstb_n    in   asynchronous active-low reset; starts a full clear sweep
//   enb       in   access enable
//   web       in   byte-lane write enables (all zero = read)
//   addrb     in   byte address (low word_shift bits ignored)
//   dinb      in   write data
//   clr_req   in   single-cycle full-clear request
//   doutb     out  read data (write-first merged word on writes)
//   rstb_busy out  clear sweep in progress; accesses ignored
//   err_oob   out  one-cycle pulse for an accepted out-of-range access
// Build option:
//   BRAM_OUTREG_EN  adds a second output register stage (read latency 2).
// INIT_FILE is accepted for interface compatibility; every reset ends in a
// full zero sweep, so a preloaded image would never be observable.
// -----------------------------------------------------------------------------
module bram_sp_clr
   import bram_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int MEM_DEPTH = 1024,
   parameter int ADDR_W    = 32,
   parameter     INIT_FILE = ""
) (
   input  logic                        clkb,
   input  logic                        rstb_n,
   input  logic                        enb,
   input  logic [lane_cnt(DATA_W)-1:0] web,
   input  logic [ADDR_W-1:0]           addrb,
   input  logic [DATA_W-1:0]           dinb,
   input  logic                        clr_req,
   output logic [DATA_W-1:0]           doutb,
   output logic                        rstb_busy,
   output logic                        err_oob
);

   localparam int LANES = lane_cnt(DATA_W);
   localparam int SHIFT = word_shift(DATA_W);
   localparam int IDX_W = $clog2(MEM_DEPTH);

   logic [DATA_W-1:0] mem_q [MEM_DEPTH];

   logic              busy;
   logic              clr_we;
   logic [IDX_W-1:0]  clr_addr;

   logic [ADDR_W-1:0] word_idx;
   logic [IDX_W-1:0]  acc_idx;
   logic              in_range;
   logic              accept;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] merged;

   logic [LANES-1:0]  wr_lane_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [DATA_W-1:0] wr_data;

   logic [DATA_W-1:0] dout_d, dout_q;
   logic              err_d, err_q;

   bram_clr_seq #(
      .MEM_DEPTH (MEM_DEPTH),
      .CTR_W     (IDX_W)
   ) u_clr_seq (
      .clk      (clkb),
      .rst_n    (rstb_n),
      .clr_req  (clr_req),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .busy     (busy)
   );

   assign rstb_busy = busy;
   assign word_idx  = addrb >> SHIFT;
   assign in_range  = (word_idx < ADDR_W'(MEM_DEPTH));
   assign acc_idx   = word_idx[IDX_W-1:0];
   assign accept    = enb && !busy;
   assign rd_word   = mem_q[acc_idx];

   // Write-first view of the addressed word: new bytes in enabled lanes.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_merge
         assign merged[gi*8 +: 8] = web[gi] ? dinb[gi*8 +: 8] : rd_word[gi*8 +: 8];
      end
   endgenerate

   // The sweep owns the write port whenever it runs; user writes are only
   // possible when it is idle, so there is never contention.
   always_comb begin
      wr_lane_en = '0;
      wr_idx     = acc_idx;
      wr_data    = dinb;
      if (clr_we) begin
         wr_lane_en = '1;
         wr_idx     = clr_addr;
         wr_data    = '0;
      end else if (accept && in_range) begin
         wr_lane_en = web;
      end
   end

   always_ff @(posedge clkb) begin
      for (int k = 0; k < LANES; k++) begin
         if (wr_lane_en[k]) begin
            mem_q[wr_idx][k*8 +: 8] <= wr_data[k*8 +: 8];
         end
      end
   end

   always_comb begin
      dout_d = dout_q;
      if (accept) begin
         dout_d = in_range ? merged : '0;
      end
   end

   assign err_d = accept && !in_range;

   always_ff @(posedge clkb or negedge rstb_n) begin
      if (!rstb_n) begin
         dout_q <= '0;
         err_q  <= 1'b0;
      end else begin
         dout_q <= dout_d;
         err_q  <= err_d;
      end
   end

`ifdef BRAM_OUTREG_EN
   logic              acc1_q;
   logic [DATA_W-1:0] dout2_q;
   logic              err2_q;

   // Second stage moves only behind an accepted access; the error flag is
   // re-registered each cycle so it stays a single-cycle pulse.
   always_ff @(posedge clkb or negedge rstb_n) begin
      if (!rstb_n) begin
         acc1_q  <= 1'b0;
         dout2_q <= '0;
         err2_q  <= 1'b0;
      end else begin
         acc1_q <= accept;
         err2_q <= err_q;
         if (acc1_q) begin
            dout2_q <= dout_q;
         end
      end
   end

   assign doutb   = dout2_q;
   assign err_oob = err2_q;
`else
   assign doutb   = dout_q;
   assign err_oob = err_q;
`endif

endmodule

// File: tb/tb_bram_sp_clr.sv
module tb_bram_sp_clr;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int AW    = 32;

   logic          clkb = 1'b0;
   logic          rstb_n = 1'b0;
   logic          enb = 1'b0;
   logic [3:0]    web = '0;
   logic [AW-1:0] addrb = '0;
   logic [DW-1:0] dinb = '0;
   logic          clr_req = 1'b0;
   logic [DW-1:0] doutb;
   logic          rstb_busy;
   logic          err_oob;

   int n_tests = 0;
   int n_fail  = 0;

   bram_sp_clr #(
      .DATA_W    (DW),
      .MEM_DEPTH (DEPTH),
      .ADDR_W    (AW),
      .INIT_FILE ("")
   ) dut (
      .clkb      (clkb),
      .rstb_n    (rstb_n),
      .enb       (enb),
      .web       (web),
      .addrb     (addrb),
      .dinb      (dinb),
      .clr_req   (clr_req),
      .doutb     (doutb),
      .rstb_busy (rstb_busy),
      .err_oob   (err_oob)
   );

   always #5 clkb = ~clkb;

   // Reference model: word array, remaining-busy countdown, output stages.
   logic [31:0] m_mem [DEPTH];
   int          busy_left;
   logic [31:0] e1_dout, e2_dout;
   logic        e1_err, e2_err, e1_acc;
   logic [31:0] exp_dout;
   logic        exp_err, exp_busy;

`ifdef BRAM_OUTREG_EN
   assign exp_dout = e2_dout;
   assign exp_err  = e2_err;
`else
   assign exp_dout = e1_dout;
   assign exp_err  = e1_err;
`endif
   assign exp_busy = (busy_left > 0);

   task automatic model_reset();
      busy_left = DEPTH;
      e1_dout = '0; e1_err = 1'b0; e1_acc = 1'b0;
      e2_dout = '0; e2_err = 1'b0;
   endtask

   task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] a,
                        input logic [31:0] d, input logic clr);
      enb = en; web = we; addrb = a; dinb = d; clr_req = clr;
   endtask

   // One clock edge: update the model from the inputs seen at the edge.
   task automatic step();
      logic [29:0] wi;
      logic        acc, oob;
      logic [31:0] nw;
      @(posedge clkb);
      if (rstb_n) begin
         e2_err = e1_err;
         if (e1_acc) e2_dout = e1_dout;
         wi  = addrb[31:2];
         oob = (wi >= 30'(DEPTH));
         acc = enb && (busy_left == 0);
         e1_acc = acc;
         e1_err = acc && oob;
         if (acc) begin
            if (oob) begin
               e1_dout = '0;
            end else begin
               nw = m_mem[wi];
               for (int k = 0; k < 4; k++)
                  if (web[k]) nw[k*8 +: 8] = dinb[k*8 +: 8];
               m_mem[wi] = nw;
               e1_dout   = nw;
            end
         end
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0)
               for (int w = 0; w < DEPTH; w++) m_mem[w] = '0;
         end else if (clr_req) begin
            busy_left = DEPTH;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rstb_n = 1'b0;
      drive(0, 4'h0, 0, 0, 0);
      model_reset();
      #2;
      n_tests++;
      if (doutb !== 32'h0 || rstb_busy !== 1'b1 || err_oob !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: dout=%h busy=%b err=%b required dout=0 busy=1 err=0",
                  doutb, rstb_busy, err_oob);
      end
      @(negedge clkb);
      rstb_n = 1'b1;
      for (int i = 1; i <= DEPTH; i++) begin
         step();
         n_tests++;
         if (rstb_busy !== exp_busy) begin
            n_fail++;
            $display("FAIL sweep_busy edge %0d: got %b required %b", i, rstb_busy, exp_busy);
         end
      end
   endtask

   task automatic test_sweep_reads();
      for (int w = 0; w <= DEPTH; w++) begin
         if (w < DEPTH) drive(1, 4'h0, 32'(w * 4), $urandom, 0);
         else           drive(0, 4'h0, 0, 0, 0);
         step();
         n_tests++;
         if (doutb !== exp_dout || doutb !== 32'h0) begin
            n_fail++;
            $display("FAIL sweep_read word %0d: got %h required 00000000", w, doutb);
         end
      end
   endtask

   task automatic test_byte_lanes();
      drive(1, 4'hF, 32'h8, 32'hAABBCCDD, 0); step();
      drive(1, 4'h5, 32'h8, 32'h11223344, 0); step();
      n_tests++;
      if (doutb !== exp_dout) begin
         n_fail++;
         $display("FAIL byte_lane_write: got %h required %h", doutb, exp_dout);
      end
      drive(1, 4'h0, 32'h8, 32'h0, 0); step();
      drive(0, 4'h0, 32'h0, 32'h0, 0); step();
      n_tests++;
      if (doutb !== 32'hAA22CC44) begin
         n_fail++;
         $display("FAIL byte_lane_read: got %h required aa22cc44", doutb);
      end
   endtask

   task automatic test_back_to_back();
      drive(1, 4'hF, 32'h4, 32'h5, 0); step();
      n_tests++;
      if (doutb !== exp_dout) begin
         n_fail++;
         $display("FAIL rdw_write: got %h required %h", doutb, exp_dout);
      end
      drive(1, 4'h0, 32'h4, 32'h0, 0); step();
      n_tests++;
      if (doutb !== exp_dout) begin
         n_fail++;
         $display("FAIL rdw_read: got %h required %h", doutb, exp_dout);
      end
      drive(0, 4'h0, 32'h0, 32'h0, 0); step();
      n_tests++;
      if (doutb !== 32'h5) begin
         n_fail++;
         $display("FAIL rdw_settled: got %h required 00000005", doutb);
      end
   endtask

   task automatic test_oob();
      drive(1, 4'hF, 32'h40, 32'hFFFFFFFF, 0);
      for (int c = 0; c < 4; c++) begin
         step();
         n_tests++;
         if (doutb !== exp_dout || err_oob !== exp_err) begin
            n_fail++;
            $display("FAIL oob cycle %0d: dout=%h err=%b required dout=%h err=%b",
                     c, doutb, err_oob, exp_dout, exp_err);
         end
         if (c == 0) drive(1, 4'h0, 32'h0, 32'h0, 0);
         else        drive(0, 4'h0, 32'h0, 32'h0, 0);
      end
      n_tests++;
      if (doutb !== 32'h0) begin
         n_fail++;
         $display("FAIL oob_word0: got %h required 00000000", doutb);
      end
   endtask

   task automatic test_clr_req();
      for (int w = 0; w < DEPTH; w++) begin
         drive(1, 4'hF, 32'(w * 4), 32'h12345678, 0); step();
      end
      drive(1, 4'hF, 32'hC, 32'hCAFE0000, 1); step();
      for (int c = 0; c < DEPTH + 2; c++) begin
         drive(1, 4'($urandom), 32'($urandom_range(0, DEPTH - 1) * 4), $urandom, 0);
         step();
         n_tests++;
         if (rstb_busy !== exp_busy || doutb !== exp_dout || err_oob !== exp_err) begin
            n_fail++;
            $display("FAIL clr_sweep cycle %0d: busy=%b dout=%h required busy=%b dout=%h",
                     c, rstb_busy, doutb, exp_busy, exp_dout);
         end
      end
      for (int w = 0; w <= DEPTH + 1; w++) begin
         if (w < DEPTH) drive(1, 4'h0, 32'(w * 4), 32'h0, 0);
         else           drive(0, 4'h0, 32'h0, 32'h0, 0);
         step();
         n_tests++;
         if (doutb !== exp_dout) begin
            n_fail++;
            $display("FAIL clr_readback %0d: got %h required %h", w, doutb, exp_dout);
         end
      end
   endtask

   task automatic test_reset_mid_sweep();
      drive(1, 4'hF, 32'hC, 32'h12345678, 1); step();
      drive(0, 4'h0, 32'h0, 32'h0, 0);
      for (int c = 0; c < 7; c++) step();
      n_tests++;
      if (doutb !== 32'h12345678 || rstb_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset: dout=%h busy=%b required 12345678 1", doutb, rstb_busy);
      end
      #2;
      rstb_n = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if (doutb !== 32'h0 || rstb_busy !== 1'b1 || err_oob !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: dout=%h busy=%b err=%b required 0 1 0",
                  doutb, rstb_busy, err_oob);
      end
      step();
      @(negedge clkb);
      rstb_n = 1'b1;
      for (int i = 1; i <= DEPTH + 1; i++) begin
         step();
         n_tests++;
         if (rstb_busy !== exp_busy) begin
            n_fail++;
            $display("FAIL resweep_busy edge %0d: got %b required %b", i, rstb_busy, exp_busy);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         drive(($urandom % 4) != 0,
               ($urandom % 2) ? 4'($urandom) : 4'h0,
               32'($urandom_range(0, DEPTH + 3) * 4 + $urandom_range(0, 3)),
               $urandom,
               ($urandom % 40) == 0);
         step();
         n_tests++;
         if (doutb !== exp_dout || err_oob !== exp_err || rstb_busy !== exp_busy) begin
            n_fail++;
            $display("FAIL random cycle %0d: dout=%h err=%b busy=%b required dout=%h err=%b busy=%b",
                     c, doutb, err_oob, rstb_busy, exp_dout, exp_err, exp_busy);
         end
      end
   endtask

   initial begin
      for (int w = 0; w < DEPTH; w++) m_mem[w] = '0;
      model_reset();
      test_reset();
      test_sweep_reads();
      test_byte_lanes();
      test_back_to_back();
      test_oob();
      test_clr_req();
      test_reset_mid_sweep();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
